// File: rtl/mat3_det_pkg.sv
// Shared types and constants for the 3x3 determinant engine.
// The determinant is expanded into six triple products (rule of Sarrus);
// each term lists the three element indices it multiplies and its sign.
package mat3_det_pkg;

  localparam int unsigned N_TERMS = 6;
  localparam int unsigned ELEM_W  = 8;
  localparam int unsigned N_ELEMS = 9;
  localparam int unsigned MAT_W   = N_ELEMS * ELEM_W;

  typedef enum logic [1:0] {
    IDLE,
    MUL_A,
    MUL_B,
    SEND
  } state_t;

  // Element indices (k = row*3 + col) for each of the six terms.
  localparam logic [0:N_TERMS-1][0:2][3:0] TERM_IDX = '{
    '{4'd0, 4'd4, 4'd8},
    '{4'd1, 4'd5, 4'd6},
    '{4'd2, 4'd3, 4'd7},
    '{4'd2, 4'd4, 4'd6},
    '{4'd0, 4'd5, 4'd7},
    '{4'd1, 4'd3, 4'd8}
  };

  // 1 = term is subtracted from the accumulator.
  localparam logic [0:N_TERMS-1] TERM_NEG = 6'b000111;

  // Pick element k out of the flattened matrix.
  function automatic logic [ELEM_W-1:0] elem_at(input logic [MAT_W-1:0] m,
                                                input logic [3:0]       k);
    return m[{k, 3'b000} +: ELEM_W];
  endfunction

endpackage

// File: rtl/mat3_det_serializer.sv
// Byte serializer: loads a full result word and presents it MSB-first,
// one byte per valid/ready handshake. done pulses with the last handshake.
module byte_serializer
  import mat3_det_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] data,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             done
);

  localparam int unsigned OUT_BYTES = ACC_W / 8;
  localparam int unsigned CNT_W     = $clog2(OUT_BYTES);

  logic [ACC_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fire;

  assign fire   = o_valid & i_ready;
  assign done   = fire && (cnt_q == CNT_W'(OUT_BYTES - 1));
  // Top byte of the shift register is always the byte on offer; once all
  // bytes are shifted out the register is zero, so o_data idles at 0.
  assign o_data = shift_q[ACC_W-1 -: 8];

  // Load a new word, or advance one byte per accepted handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      o_valid <= 1'b0;
    end else if (load) begin
      shift_q <= data;
      cnt_q   <= '0;
      o_valid <= 1'b1;
    end else if (fire) begin
      shift_q <= {shift_q[ACC_W-9:0], 8'h00};
      cnt_q   <= cnt_q + CNT_W'(1);
      if (done) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mat3_det.sv
// 3x3 unsigned-byte matrix determinant with a single shared multiplier.
// Each of the six terms takes two cycles (x*y, then *z and accumulate);
// the signed result is presented in parallel with a strobe and streamed
// MSB-first through the byte serializer.
module mat3_det
  import mat3_det_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [MAT_W-1:0] i_mat,
  input  logic             i_recvd,
  output logic             o_busy,
  output logic [ACC_W-1:0] o_det,
  output logic             o_det_strobe,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int unsigned OUT_BYTES = ACC_W / 8;

  state_t           state_q;
  logic [MAT_W-1:0] mat_q;
  logic [2:0]       term_q;
  logic [15:0]      p16_q;
  logic [ACC_W-1:0] acc_q;
  logic             recvd_q;

  logic             start;
  logic             last_term;
  logic [7:0]       op_x;
  logic [7:0]       op_y;
  logic [7:0]       op_z;
  logic [23:0]      prod24;
  logic [ACC_W-1:0] acc_next;
  logic             ser_load;
  logic             ser_done;

  // Remember last cycle's i_recvd for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      recvd_q <= 1'b0;
    end else begin
      recvd_q <= i_recvd;
    end
  end

  // Edges outside IDLE are dropped, not queued.
  assign start     = i_recvd & ~recvd_q & (state_q == IDLE);
  assign last_term = (term_q == 3'(N_TERMS - 1));

  // Operand selection and the accumulate step for the current term.
  always_comb begin
    op_x     = elem_at(mat_q, TERM_IDX[term_q][0]);
    op_y     = elem_at(mat_q, TERM_IDX[term_q][1]);
    op_z     = elem_at(mat_q, TERM_IDX[term_q][2]);
    prod24   = 24'(p16_q) * 24'(op_z);
    acc_next = acc_q + ACC_W'(prod24);
    if (TERM_NEG[term_q]) begin
      acc_next = acc_q - ACC_W'(prod24);
    end
  end

  // The serializer picks up the result on the same edge that o_det does,
  // so the first byte is valid in the strobe cycle.
  assign ser_load = (state_q == MUL_B) && last_term;

  // Control FSM: capture, six two-cycle terms, then wait for the stream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      mat_q        <= '0;
      term_q       <= '0;
      p16_q        <= '0;
      acc_q        <= '0;
      o_busy       <= 1'b0;
      o_det        <= '0;
      o_det_strobe <= 1'b0;
    end else begin
      o_det_strobe <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mat_q   <= i_mat;
            acc_q   <= '0;
            term_q  <= '0;
            o_busy  <= 1'b1;
            state_q <= MUL_A;
          end
        end
        MUL_A: begin
          p16_q   <= 16'(op_x) * 16'(op_y);
          state_q <= MUL_B;
        end
        MUL_B: begin
          acc_q <= acc_next;
          if (last_term) begin
            o_det        <= acc_next;
            o_det_strobe <= 1'b1;
            state_q      <= SEND;
          end else begin
            term_q  <= term_q + 3'd1;
            state_q <= MUL_A;
          end
        end
        SEND: begin
          if (ser_done) begin
            o_busy  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  byte_serializer #(
    .ACC_W (ACC_W)
  ) u_ser (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .load    (ser_load),
    .data    (acc_next),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .done    (ser_done)
  );

endmodule

// File: tb/tb_mat3_det.sv
// Self-checking bench for mat3_det: directed vectors, randomized matrices
// against a cofactor-expansion reference, backpressure and control cases.
module tb_mat3_det;

  logic        i_clk;
  logic        i_rst_n;
  logic [71:0] i_mat;
  logic        i_recvd;
  logic        o_busy;
  logic [31:0] o_det;
  logic        o_det_strobe;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;

  mat3_det #(.ACC_W(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_mat        (i_mat),
    .i_recvd      (i_recvd),
    .o_busy       (o_busy),
    .o_det        (o_det),
    .o_det_strobe (o_det_strobe),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Observations from the most recent run_mat call.
  int          obs_strobe_off;
  int          obs_nstrobe;
  int          obs_nbytes;
  int          obs_idle_off;
  logic [31:0] obs_det;
  logic [31:0] obs_bytes;
  int          obs_boff [4];
  logic        obs_stall_ok;

  function automatic logic [71:0] mk(input int a, input int b, input int c,
                                     input int d, input int e, input int f,
                                     input int g, input int h, input int i);
    return {i[7:0], h[7:0], g[7:0], f[7:0], e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Reference: cofactor expansion along the first row.
  function automatic logic [31:0] ref_det(input logic [71:0] m);
    int e [9];
    int d;
    for (int k = 0; k < 9; k++) e[k] = int'(m[8*k +: 8]);
    d = e[0] * (e[4] * e[8] - e[5] * e[7])
      - e[1] * (e[3] * e[8] - e[5] * e[6])
      + e[2] * (e[3] * e[7] - e[4] * e[6]);
    return 32'(d);
  endfunction

  function automatic logic [71:0] rand_mat();
    logic [71:0] m;
    for (int k = 0; k < 9; k++) begin
      case ($urandom_range(0, 3))
        0:       m[8*k +: 8] = 8'h00;
        1:       m[8*k +: 8] = 8'hFF;
        default: m[8*k +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return m;
  endfunction

  // Start a computation at the current negedge and observe it until the
  // block goes idle. Offsets are cycles relative to the start-edge cycle N.
  task automatic run_mat(input logic [71:0] m, input bit pre_low,
                         input int stall_at, input int stall_len,
                         input bit toggle, input bit drop);
    int n0;
    int off;
    int stall_left;
    bit stall_done;
    logic [7:0] held;
    if (pre_low) begin
      i_recvd = 1'b0;
      @(negedge i_clk);
    end
    i_mat = m;
    i_recvd = 1'b1;
    i_ready = 1'b1;
    n0 = cyc;
    obs_strobe_off = -1; obs_nstrobe = 0; obs_nbytes = 0; obs_idle_off = -1;
    obs_det = '0; obs_bytes = '0; obs_stall_ok = 1'b1;
    for (int j = 0; j < 4; j++) obs_boff[j] = -1;
    stall_left = 0; stall_done = 0; held = '0;
    for (int k = 0; k < 120; k++) begin
      @(negedge i_clk);
      off = cyc - n0;
      if (off == 2) i_mat = ~m;
      if (toggle && off == 3) i_recvd = 1'b0;
      if (toggle && off == 4) i_recvd = 1'b1;
      if (drop && off == 5) i_recvd = 1'b0;
      if (o_det_strobe) begin
        obs_nstrobe++;
        obs_strobe_off = off;
        obs_det = o_det;
      end
      if (stall_at >= 0 && !stall_done && o_valid && obs_nbytes == stall_at) begin
        stall_done = 1;
        stall_left = stall_len;
        held = o_data;
      end
      if (stall_left > 0) begin
        i_ready = 1'b0;
        stall_left--;
        if (o_valid !== 1'b1 || o_data !== held) obs_stall_ok = 1'b0;
      end else begin
        i_ready = 1'b1;
      end
      if (o_valid && i_ready) begin
        if (obs_nbytes < 4) begin
          obs_bytes = {obs_bytes[23:0], o_data};
          obs_boff[obs_nbytes] = off;
        end
        obs_nbytes++;
      end
      if (obs_nbytes >= 4 && !o_busy) begin
        obs_idle_off = off;
        break;
      end
    end
    i_ready = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_recvd = 1'b0; i_ready = 1'b0; i_mat = '0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_busy, o_det, o_det_strobe, o_data, o_valid} !== '0)
      begin errors++; $display("FAIL reset_outputs: got busy=%b det=%h strb=%b data=%h valid=%b, expected all 0", o_busy, o_det, o_det_strobe, o_data, o_valid); end
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: got busy=%b valid=%b, expected 0 0", o_busy, o_valid); end
  endtask

  task automatic test_identity();
    run_mat(mk(1,0,0, 0,1,0, 0,0,1), 1, -1, 0, 0, 0);
    checks++;
    if (obs_nstrobe !== 1 || obs_strobe_off !== 13)
      begin errors++; $display("FAIL id_strobe: got count=%0d at N+%0d, expected 1 at N+13", obs_nstrobe, obs_strobe_off); end
    checks++;
    if (obs_det !== 32'd1) begin errors++; $display("FAIL id_det: got %h expected 00000001", obs_det); end
    checks++;
    if (obs_bytes !== 32'h00000001) begin errors++; $display("FAIL id_bytes: got %h expected 00000001", obs_bytes); end
    checks++;
    if (obs_boff[0] !== 13 || obs_boff[1] !== 14 || obs_boff[2] !== 15 || obs_boff[3] !== 16)
      begin errors++; $display("FAIL id_byte_cycles: got %0d %0d %0d %0d expected 13 14 15 16", obs_boff[0], obs_boff[1], obs_boff[2], obs_boff[3]); end
    checks++;
    if (obs_idle_off !== 17) begin errors++; $display("FAIL id_busy_low: got N+%0d expected N+17", obs_idle_off); end
  endtask

  task automatic test_level_held();
    int extra;
    extra = 0;
    // i_recvd is still high from the previous run.
    repeat (20) begin
      @(negedge i_clk);
      if (o_det_strobe || o_valid || o_busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL level_held: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_vectors();
    logic [71:0] mats [4];
    logic [31:0] exps [4];
    mats[0] = mk(255,255,255, 255,255,255, 255,255,255); exps[0] = 32'h00000000;
    mats[1] = mk(0,1,0, 1,0,0, 0,0,1);                   exps[1] = 32'hFFFFFFFF;
    mats[2] = mk(255,0,255, 255,255,0, 0,255,255);       exps[2] = 32'h01FA05FE;
    mats[3] = mk(255,0,0, 0,255,0, 0,0,255);             exps[3] = 32'h00FD02FF;
    for (int v = 0; v < 4; v++) begin
      run_mat(mats[v], 1, -1, 0, 0, 0);
      checks++;
      if (obs_det !== exps[v]) begin errors++; $display("FAIL vec%0d_det: got %h expected %h", v, obs_det, exps[v]); end
      checks++;
      if (obs_bytes !== exps[v] || obs_nbytes !== 4)
        begin errors++; $display("FAIL vec%0d_bytes: got %h (%0d bytes) expected %h (4 bytes)", v, obs_bytes, obs_nbytes, exps[v]); end
    end
  endtask

  task automatic test_backpressure();
    run_mat(mk(255,0,255, 255,255,0, 0,255,255), 1, 1, 5, 0, 0);
    checks++;
    if (obs_stall_ok !== 1'b1) begin errors++; $display("FAIL bp_stable: got unstable output, expected data FA held with valid=1"); end
    checks++;
    if (obs_bytes !== 32'h01FA05FE || obs_nbytes !== 4)
      begin errors++; $display("FAIL bp_bytes: got %h (%0d bytes) expected 01fa05fe", obs_bytes, obs_nbytes); end
    checks++;
    if (obs_boff[1] !== 19 || obs_idle_off !== 22)
      begin errors++; $display("FAIL bp_timing: got byte1 at N+%0d idle at N+%0d expected 19 and 22", obs_boff[1], obs_idle_off); end
  endtask

  task automatic test_restart_ignored();
    logic [71:0] m;
    int extra;
    m = rand_mat();
    run_mat(m, 1, -1, 0, 1, 0);
    checks++;
    if (obs_nstrobe !== 1 || obs_det !== ref_det(m))
      begin errors++; $display("FAIL toggle_single: got %0d results det=%h expected 1 det=%h", obs_nstrobe, obs_det, ref_det(m)); end
    extra = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_det_strobe || o_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL toggle_no_rerun: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_random();
    logic [71:0] m;
    int sa;
    for (int t = 0; t < 16; t++) begin
      m = rand_mat();
      sa = (t % 2 == 0) ? -1 : int'($urandom_range(0, 3));
      run_mat(m, 1, sa, int'($urandom_range(1, 4)), 0, 0);
      checks++;
      if (obs_det !== ref_det(m) || obs_strobe_off !== 13)
        begin errors++; $display("FAIL rand%0d_det: got %h at N+%0d expected %h at N+13", t, obs_det, obs_strobe_off, ref_det(m)); end
      checks++;
      if (obs_bytes !== ref_det(m) || obs_nbytes !== 4 || obs_stall_ok !== 1'b1)
        begin errors++; $display("FAIL rand%0d_bytes: got %h (%0d bytes, stable=%b) expected %h", t, obs_bytes, obs_nbytes, obs_stall_ok, ref_det(m)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [71:0] ma;
    logic [71:0] mb;
    ma = mk(3,1,4, 1,5,9, 2,6,5);
    mb = mk(2,7,1, 8,2,8, 1,8,2);
    run_mat(ma, 1, -1, 0, 0, 1);
    checks++;
    if (obs_det !== ref_det(ma) || obs_idle_off !== 17)
      begin errors++; $display("FAIL b2b_first: got %h idle N+%0d expected %h idle N+17", obs_det, obs_idle_off, ref_det(ma)); end
    run_mat(mb, 0, -1, 0, 0, 0);
    checks++;
    if (obs_det !== ref_det(mb) || obs_strobe_off !== 13 || obs_bytes !== ref_det(mb))
      begin errors++; $display("FAIL b2b_second: got det=%h bytes=%h at N+%0d expected %h at N+13", obs_det, obs_bytes, obs_strobe_off, ref_det(mb)); end
  endtask

  task automatic test_mid_reset();
    logic [71:0] m;
    int seen;
    i_recvd = 1'b0;
    @(negedge i_clk);
    i_mat = mk(255,0,255, 255,255,0, 0,255,255);
    i_recvd = 1'b1;
    i_ready = 1'b1;
    repeat (6) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL midrst_running: got busy=%b expected 1", o_busy); end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_det, o_det_strobe, o_data, o_valid} !== '0)
      begin errors++; $display("FAIL midrst_outputs: got busy=%b det=%h strb=%b data=%h valid=%b, expected all 0", o_busy, o_det, o_det_strobe, o_data, o_valid); end
    seen = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_valid || o_busy || o_det_strobe) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", seen); end
    // Release with i_recvd already high: the first cycle counts as an edge.
    m = rand_mat();
    i_rst_n = 1'b1;
    run_mat(m, 0, -1, 0, 0, 0);
    checks++;
    if (obs_det !== ref_det(m) || obs_strobe_off !== 13 || obs_bytes !== ref_det(m))
      begin errors++; $display("FAIL midrst_fresh: got det=%h bytes=%h at N+%0d expected %h at N+13", obs_det, obs_bytes, obs_strobe_off, ref_det(m)); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_level_held();
    test_vectors();
    test_backpressure();
    test_restart_ignored();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
